jk_ff_controller: RTL and testbench

//   Sequences a jk_flip_flop from Basys3 user inputs.
//   - Switches select the J/K command; a debounced button press arms it.
//   - The command is applied to the flip-flop for exactly one clk cycle, aligned to a slow tick.
//   - Sits between SW0/SW1/BTN0 and the flip-flop's J/K inputs. All logic runs on clk (100 MHz).

---
 rtl/jk_ff_controller.sv | 166 ++++++++++++++++
 tb/tb_jk_ff_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_ff_controller.sv
// jk_ff_controller: sequences a J/K flip-flop from Basys3 switches and a button.
// The switches pick the J/K command and a debounced button press arms it.
// The command then reaches the flip-flop for exactly one clk cycle, right after a slow tick.
// Optional feature: define JK_AUTO_SEQ_EN to add the auto_en port.
// That port replays a fixed command sequence on every tick while the FSM is idle.
module jk_ff_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_DIV        = 50_000_000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_j,
  input  logic             sw_k,
  input  logic             btn_go,
`ifdef JK_AUTO_SEQ_EN
  input  logic             auto_en,
`endif
  output logic             jk_j,
  output logic             jk_k,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] cmd_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_APPLY, S_RELEASE} state_t;

  logic [1:0]       sync_j_q, sync_j_d;
  logic [1:0]       sync_k_q, sync_k_d;
  logic [1:0]       sync_btn_q, sync_btn_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             stable_q, stable_d;
  logic             stable_prev_q, stable_prev_d;
  logic [TK_W-1:0]  div_q, div_d;
  state_t           state_q, state_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [1:0]       jk_q, jk_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             press;
  logic             tick_w;

`ifdef JK_AUTO_SEQ_EN
  logic [1:0] sync_auto_q, sync_auto_d;
  logic [2:0] seq_idx_q, seq_idx_d;

  function automatic logic [1:0] seq_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    seq_entry = 2'b10;
      3'd1:    seq_entry = 2'b01;
      3'd2:    seq_entry = 2'b11;
      3'd3:    seq_entry = 2'b11;
      default: seq_entry = 2'b00;
    endcase
  endfunction
`endif

  // A press is the first cycle in which the debounced level reads high.
  assign press     = stable_q & ~stable_prev_q;
  assign tick_w    = (div_q == TK_LAST);
  assign tick      = tick_w;
  assign busy      = (state_q != S_IDLE);
  assign jk_j      = jk_q[1];
  assign jk_k      = jk_q[0];
  assign cmd_count = count_q;

  // Next-state logic: input conditioning, tick divider and the command FSM.
  always_comb begin
    sync_j_d      = {sync_j_q[0], sw_j};
    sync_k_d      = {sync_k_q[0], sw_k};
    sync_btn_d    = {sync_btn_q[0], btn_go};
    db_cnt_d      = db_cnt_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    div_d         = tick_w ? '0 : div_q + TK_W'(1);
    state_d       = state_q;
    cmd_d         = cmd_q;
    count_d       = count_q;
`ifdef JK_AUTO_SEQ_EN
    sync_auto_d   = {sync_auto_q[0], auto_en};
    seq_idx_d     = sync_auto_q[1] ? seq_idx_q : 3'd0;
`endif

    if (sync_btn_q[1] == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      stable_d = sync_btn_q[1];
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end

    case (state_q)
      S_IDLE: begin
`ifdef JK_AUTO_SEQ_EN
        if (sync_auto_q[1]) begin
          if (tick_w) begin
            cmd_d     = seq_entry(seq_idx_q);
            seq_idx_d = (seq_idx_q == 3'd4) ? 3'd0 : seq_idx_q + 3'd1;
            state_d   = S_APPLY;
          end
        end else
`endif
        if (press) begin
          cmd_d   = {sync_j_q[1], sync_k_q[1]};
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (tick_w) state_d = S_APPLY;
      end
      S_APPLY: begin
        count_d = count_q + CNT_W'(1);
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!stable_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    jk_d = (state_d == S_APPLY) ? cmd_d : 2'b00;
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_j_q      <= '0;
      sync_k_q      <= '0;
      sync_btn_q    <= '0;
      db_cnt_q      <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      div_q         <= '0;
      state_q       <= S_IDLE;
      cmd_q         <= 2'b00;
      jk_q          <= 2'b00;
      count_q       <= '0;
`ifdef JK_AUTO_SEQ_EN
      sync_auto_q   <= '0;
      seq_idx_q     <= 3'd0;
`endif
    end else begin
      sync_j_q      <= sync_j_d;
      sync_k_q      <= sync_k_d;
      sync_btn_q    <= sync_btn_d;
      db_cnt_q      <= db_cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      div_q         <= div_d;
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      jk_q          <= jk_d;
      count_q       <= count_d;
`ifdef JK_AUTO_SEQ_EN
      sync_auto_q   <= sync_auto_d;
      seq_idx_q     <= seq_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_jk_ff_controller.sv
// Testbench for jk_ff_controller with short debounce and tick periods.
module tb_jk_ff_controller;
  localparam int DB = 4;
  localparam int TD = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sw_j, sw_k, btn_go;
  logic          jk_j, jk_k, busy, tick;
  logic [CW-1:0] cmd_count;

  jk_ff_controller #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .sw_j(sw_j), .sw_k(sw_k), .btn_go(btn_go),
    .jk_j(jk_j), .jk_k(jk_k), .busy(busy), .tick(tick), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  int passCount = 0;
  int checkCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles since reset release; a tick is due every TD-th cycle.
  int unsigned cycN;
  always @(posedge clk or posedge rst) begin
    if (rst) cycN <= 0;
    else     cycN <= cycN + 1;
  end

  // Monitor plus a flip-flop model that is driven by the DUT outputs.
  logic       prevTick = 1'b0;
  int         nonHold = 0;
  logic [1:0] lastJk = 2'b00;
  logic       ffQ = 1'b0;
  always @(negedge clk) begin
    checkOutput("tick", {31'b0, tick}, ((cycN % TD) == TD - 1) ? 1 : 0);
    if ({jk_j, jk_k} != 2'b00) begin
      nonHold++;
      lastJk = {jk_j, jk_k};
      checkOutput("apply_after_tick", {31'b0, prevTick}, 1);
      checkOutput("busy_in_apply", {31'b0, busy}, 1);
      case ({jk_j, jk_k})
        2'b10:   ffQ = 1'b1;
        2'b01:   ffQ = 1'b0;
        2'b11:   ffQ = ~ffQ;
        default: ;
      endcase
    end
    prevTick = tick;
  end

  logic [CW-1:0] expCount = '0;
  logic          expQ = 1'b0;

  task automatic applyStimulus(input logic j, input logic k, input bit bounce, input bit glitch);
    int lat;
    int w;
    int nh0;
    logic sawBusy;
    logic [1:0] cmd;
    cmd = {j, k};
    sawBusy = 1'b0;
    @(negedge clk);
    sw_j = j;
    sw_k = k;
    repeat ($urandom_range(3, 12)) @(negedge clk);
    nh0 = nonHold;
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        btn_go = ~btn_go;
        repeat (2) begin
          @(negedge clk);
          sawBusy = sawBusy | busy;
        end
      end
      checkOutput("no_press_while_bouncing", {31'b0, sawBusy}, 0);
    end
    btn_go = 1'b1;
    lat = 0;
    while (!busy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("press_latency", lat, DB + 3);
    sw_j = 1'($urandom);
    sw_k = 1'($urandom);
    expCount = expCount + 1'b1;
    w = 0;
    while (cmd_count !== expCount && w < TD + 4) begin
      @(negedge clk);
      w++;
    end
    checkOutput("cmd_count", cmd_count, expCount);
    checkOutput("nonhold_cycles", nonHold - nh0, (cmd != 2'b00) ? 1 : 0);
    if (cmd != 2'b00) checkOutput("applied_jk", lastJk, cmd);
    case (cmd)
      2'b10:   expQ = 1'b1;
      2'b01:   expQ = 1'b0;
      2'b11:   expQ = ~expQ;
      default: ;
    endcase
    checkOutput("ff_q", ffQ, expQ);
    repeat ($urandom_range(0, 10)) @(negedge clk);
    checkOutput("busy_while_held", busy, 1);
    if (glitch) begin
      btn_go = 1'b0;
      repeat (2) @(negedge clk);
      btn_go = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("busy_after_glitch", busy, 1);
      checkOutput("count_after_glitch", cmd_count, expCount);
    end
    btn_go = 1'b0;
    lat = 0;
    while (busy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("release_latency", lat, DB + 3);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int nh0;
    rst = 1'b1;
    sw_j = 1'b0;
    sw_k = 1'b0;
    btn_go = 1'b0;
    #12;
    checkOutput("rst_jk_j", jk_j, 0);
    checkOutput("rst_jk_k", jk_k, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_tick", tick, 0);
    checkOutput("rst_count", cmd_count, 0);
    #8;
    rst = 1'b0;

    $display("[TB] set command");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    $display("[TB] bouncing button");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    $display("[TB] toggle twice then hold");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset while armed");
    @(negedge clk);
    sw_j = 1'b1;
    sw_k = 1'b0;
    repeat (4) @(negedge clk);
    btn_go = 1'b1;
    w = 0;
    while (!busy && w < 40) begin
      @(negedge clk);
      w++;
    end
    checkOutput("armed_before_reset", busy, 1);
    nh0 = nonHold;
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_jk", {jk_j, jk_k}, 2'b00);
    checkOutput("midrst_count", cmd_count, 0);
    btn_go = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    expCount = '0;
    repeat (30) @(negedge clk);
    checkOutput("no_apply_after_reset", nonHold - nh0, 0);
    checkOutput("count_after_reset", cmd_count, 0);
    checkOutput("idle_after_reset", busy, 0);

    $display("[TB] wrap with random commands");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'b0, (i % 64) == 5);
    end
    checkOutput("wrap_to_zero", cmd_count, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
